// File: rtl/term_pkg.sv
// Shared constants for the terminal write controller: geometry defaults,
// FSM state encoding, PS/2 E0 cursor scan codes and control characters.
package term_pkg;

  localparam int COLS_DEFAULT      = 70;
  localparam int ROWS_DEFAULT      = 30;
  localparam int BUF_DEPTH_DEFAULT = 8190;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WRITE      = 2'd1;
  localparam logic [1:0] ST_SCROLL_CLR = 2'd2;
  localparam logic [1:0] ST_FULL_CLR   = 2'd3;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/term_addr_gen.sv
// Combinational character-buffer address: roll_cnt + y*COLS + x, folded
// back into the ring with a single conditional subtract of BUF_DEPTH.
module term_addr_gen #(
  parameter int COLS      = 70,
  parameter int BUF_DEPTH = 8190
) (
  input  logic [12:0] roll_cnt,
  input  logic [6:0]  x,
  input  logic [4:0]  y,
  output logic [12:0] addr
);

  logic [13:0] w_row_off;
  logic [13:0] w_sum;

  assign w_row_off = 14'(y) * 14'(COLS);
  assign w_sum     = 14'(roll_cnt) + w_row_off + 14'(x);
  assign addr      = (w_sum >= 14'(BUF_DEPTH)) ? 13'(w_sum - 14'(BUF_DEPTH)) : w_sum[12:0];

endmodule

// File: rtl/term_write_ctrl.sv
// Text-terminal write controller: turns key events into character-buffer
// writes, cursor moves, scrolling and full clears. Optional: TERM_CURSOR_BLINK_EN.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int COLS         = COLS_DEFAULT,
  parameter int ROWS         = ROWS_DEFAULT,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEFAULT,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic        key_ext,
  input  logic [7:0]  key_code,
  output logic        key_ready,
  input  logic        clear_req,
  output logic        vm_we,
  output logic [12:0] vm_waddr,
  output logic [7:0]  vm_wdata,
  output logic [12:0] roll_cnt,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        cursor_vis,
  output logic        busy
);

  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [4:0] LAST_Y = 5'(ROWS - 1);
  localparam logic [4:0] END_Y  = 5'(ROWS);

  logic [1:0]  r_state, w_state_next;
  logic [12:0] r_roll, w_roll_next;
  logic [6:0]  r_x, w_x_next;
  logic [4:0]  r_y, w_y_next;
  logic        r_we, w_we_next;
  logic [12:0] r_waddr, w_waddr_next;
  logic [7:0]  r_wdata, w_wdata_next;
  logic [6:0]  r_clr_x, w_clr_x_next;
  logic [4:0]  r_clr_y, w_clr_y_next;
  logic        r_scroll, w_scroll_next;

  logic        w_key_path, w_in_clr, w_is_bs, w_bs_ok, w_at_right, w_at_bottom, w_newline;
  logic [6:0]  w_bs_x, w_base_x, w_adv_x, w_gen_x;
  logic [4:0]  w_bs_y, w_base_y, w_adv_y, w_gen_y;
  logic [13:0] w_roll_sum;
  logic [12:0] w_roll_adv, w_addr;

  assign w_key_path  = (r_state == ST_IDLE) && !clear_req;
  assign w_in_clr    = (r_state == ST_SCROLL_CLR) || (r_state == ST_FULL_CLR);
  assign w_is_bs     = !key_ext && (key_code == ASCII_BS);
  assign w_at_right  = (r_x == LAST_X);
  assign w_at_bottom = (r_y == LAST_Y);
  assign w_bs_ok     = (r_x != '0) || (r_y != '0);
  assign w_bs_x      = (r_x != '0) ? r_x - 7'd1 : LAST_X;
  assign w_bs_y      = (r_x != '0) ? r_y : r_y - 5'd1;

  // Clear walkers hold the next position to blank; outside a clear the base
  // is the first position of the clear that is about to start.
  assign w_base_x = w_in_clr ? r_clr_x : '0;
  assign w_base_y = w_in_clr ? r_clr_y : ((r_state == ST_WRITE) ? LAST_Y : '0);
  assign w_adv_x  = (w_base_x == LAST_X) ? '0 : w_base_x + 7'd1;
  assign w_adv_y  = (w_base_x == LAST_X) ? w_base_y + 5'd1 : w_base_y;

  assign w_gen_x = !w_key_path ? w_base_x : (w_is_bs ? w_bs_x : r_x);
  assign w_gen_y = !w_key_path ? w_base_y : (w_is_bs ? w_bs_y : r_y);

  assign w_roll_sum = {1'b0, r_roll} + 14'(COLS);
  assign w_roll_adv = (w_roll_sum >= 14'(BUF_DEPTH)) ? 13'(w_roll_sum - 14'(BUF_DEPTH))
                                                     : w_roll_sum[12:0];

  term_addr_gen #(.COLS(COLS), .BUF_DEPTH(BUF_DEPTH)) u_addr_gen (
    .roll_cnt (r_roll),
    .x        (w_gen_x),
    .y        (w_gen_y),
    .addr     (w_addr)
  );

  always_comb begin
    w_state_next  = r_state;
    w_roll_next   = r_roll;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_we_next     = 1'b0;
    w_waddr_next  = r_waddr;
    w_wdata_next  = r_wdata;
    w_clr_x_next  = r_clr_x;
    w_clr_y_next  = r_clr_y;
    w_scroll_next = r_scroll;
    w_newline     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_next = ST_FULL_CLR;
          w_we_next    = 1'b1;
          w_waddr_next = w_addr;
          w_wdata_next = ASCII_SPACE;
          w_clr_x_next = w_adv_x;
          w_clr_y_next = w_adv_y;
        end else if (key_valid) begin
          w_state_next  = ST_WRITE;
          w_scroll_next = 1'b0;
          if (key_ext) begin
            case (key_code)
              SC_UP:    if (r_y != '0)   w_y_next = r_y - 5'd1;
              SC_DOWN:  if (!w_at_bottom) w_y_next = r_y + 5'd1;
              SC_LEFT:  if (r_x != '0)   w_x_next = r_x - 7'd1;
              SC_RIGHT: if (!w_at_right)  w_x_next = r_x + 7'd1;
              default:  ;
            endcase
          end else if (is_printable(key_code)) begin
            w_we_next    = 1'b1;
            w_waddr_next = w_addr;
            w_wdata_next = key_code;
            if (w_at_right) begin
              w_x_next  = '0;
              w_newline = 1'b1;
            end else begin
              w_x_next = r_x + 7'd1;
            end
          end else if (key_code == ASCII_CR) begin
            w_x_next  = '0;
            w_newline = 1'b1;
          end else if (w_is_bs && w_bs_ok) begin
            w_x_next     = w_bs_x;
            w_y_next     = w_bs_y;
            w_we_next    = 1'b1;
            w_waddr_next = w_addr;
            w_wdata_next = ASCII_SPACE;
          end
          if (w_newline) begin
            if (!w_at_bottom) begin
              w_y_next = r_y + 5'd1;
            end else begin
              w_roll_next   = w_roll_adv;
              w_scroll_next = 1'b1;
            end
          end
        end
      end
      ST_WRITE: begin
        if (r_scroll) begin
          w_state_next = ST_SCROLL_CLR;
          w_we_next    = 1'b1;
          w_waddr_next = w_addr;
          w_wdata_next = ASCII_SPACE;
          w_clr_x_next = w_adv_x;
          w_clr_y_next = w_adv_y;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        // Both clears end once the walker has stepped past the last row.
        if (r_clr_y == END_Y) begin
          w_state_next = ST_IDLE;
          if (r_state == ST_FULL_CLR) begin
            w_x_next = '0;
            w_y_next = '0;
          end
        end else begin
          w_we_next    = 1'b1;
          w_waddr_next = w_addr;
          w_clr_x_next = w_adv_x;
          w_clr_y_next = w_adv_y;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= ST_IDLE;
      r_roll   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_clr_x  <= '0;
      r_clr_y  <= '0;
      r_scroll <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_roll   <= w_roll_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_we     <= w_we_next;
      r_waddr  <= w_waddr_next;
      r_wdata  <= w_wdata_next;
      r_clr_x  <= w_clr_x_next;
      r_clr_y  <= w_clr_y_next;
      r_scroll <= w_scroll_next;
    end
  end

`ifdef TERM_CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_vis;
  logic               w_move;

  assign w_move = (w_x_next != r_x) || (w_y_next != r_y);

  // A cursor move restarts the period with the cursor shown.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_blink_cnt <= '0;
      r_vis       <= 1'b1;
    end else if (w_move) begin
      r_blink_cnt <= '0;
      r_vis       <= 1'b1;
    end else if (r_blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
      r_blink_cnt <= '0;
      r_vis       <= ~r_vis;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign cursor_vis = r_vis;
`else
  assign cursor_vis = (BLINK_PERIOD > 0) | 1'b1;
`endif

  assign key_ready = (r_state == ST_IDLE) && !clear_req;
  assign busy      = (r_state != ST_IDLE);
  assign vm_we     = r_we;
  assign vm_waddr  = r_waddr;
  assign vm_wdata  = r_wdata;
  assign roll_cnt  = r_roll;
  assign cursor_x  = r_x;
  assign cursor_y  = r_y;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Self-checking bench for term_write_ctrl: a table of single key events plus
// directed scroll, ring-wrap, full-clear and mid-scroll reset sequences.
module tb_term_write_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ext = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_ready;
  logic        clear_req = 1'b0;
  logic        vm_we;
  logic [12:0] vm_waddr;
  logic [7:0]  vm_wdata;
  logic [12:0] roll_cnt;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_vis;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] q_addr[$];
  logic [7:0]  q_data[$];

  typedef struct {
    logic        ext;
    logic [7:0]  code;
    logic        exp_we;
    logic [12:0] exp_addr;
    logic [7:0]  exp_data;
    logic [6:0]  exp_x;
    logic [4:0]  exp_y;
  } vec_t;

  vec_t vecs[20];

  term_write_ctrl dut (
    .clk        (clk),
    .clrn       (clrn),
    .key_valid  (key_valid),
    .key_ext    (key_ext),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .clear_req  (clear_req),
    .vm_we      (vm_we),
    .vm_waddr   (vm_waddr),
    .vm_wdata   (vm_wdata),
    .roll_cnt   (roll_cnt),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .cursor_vis (cursor_vis),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present one key, then follow the operation until busy drops (bounded).
  task automatic send_key(input logic ext, input logic [7:0] code, output int nbusy);
    int n;
    n = 0;
    q_addr.delete();
    q_data.delete();
    key_valid = 1'b1;
    key_ext   = ext;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
    while (busy && n < 5000) begin
      n++;
      if (vm_we) begin
        q_addr.push_back(vm_waddr);
        q_data.push_back(vm_wdata);
      end
      @(posedge clk); #1;
    end
    nbusy = n;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int bad;
    int bad_ready;

    vecs[0]  = '{1'b0, 8'h41, 1'b1, 13'd0,   8'h41, 7'd1,  5'd0};
    vecs[1]  = '{1'b0, 8'h42, 1'b1, 13'd1,   8'h42, 7'd2,  5'd0};
    vecs[2]  = '{1'b0, 8'h0D, 1'b0, 13'd0,   8'h00, 7'd0,  5'd1};
    vecs[3]  = '{1'b0, 8'h08, 1'b1, 13'd69,  8'h20, 7'd69, 5'd0};
    vecs[4]  = '{1'b1, 8'h75, 1'b0, 13'd0,   8'h00, 7'd69, 5'd0};
    vecs[5]  = '{1'b1, 8'h74, 1'b0, 13'd0,   8'h00, 7'd69, 5'd0};
    vecs[6]  = '{1'b1, 8'h72, 1'b0, 13'd0,   8'h00, 7'd69, 5'd1};
    vecs[7]  = '{1'b0, 8'h78, 1'b1, 13'd139, 8'h78, 7'd0,  5'd2};
    vecs[8]  = '{1'b1, 8'h6B, 1'b0, 13'd0,   8'h00, 7'd0,  5'd2};
    vecs[9]  = '{1'b1, 8'h75, 1'b0, 13'd0,   8'h00, 7'd0,  5'd1};
    vecs[10] = '{1'b0, 8'h01, 1'b0, 13'd0,   8'h00, 7'd0,  5'd1};
    vecs[11] = '{1'b1, 8'h11, 1'b0, 13'd0,   8'h00, 7'd0,  5'd1};
    vecs[12] = '{1'b0, 8'h20, 1'b1, 13'd70,  8'h20, 7'd1,  5'd1};
    vecs[13] = '{1'b0, 8'h7F, 1'b0, 13'd0,   8'h00, 7'd1,  5'd1};
    vecs[14] = '{1'b0, 8'h7E, 1'b1, 13'd71,  8'h7E, 7'd2,  5'd1};
    vecs[15] = '{1'b0, 8'h08, 1'b1, 13'd71,  8'h20, 7'd1,  5'd1};
    vecs[16] = '{1'b0, 8'h1F, 1'b0, 13'd0,   8'h00, 7'd1,  5'd1};
    vecs[17] = '{1'b1, 8'h41, 1'b0, 13'd0,   8'h00, 7'd1,  5'd1};
    vecs[18] = '{1'b1, 8'h08, 1'b0, 13'd0,   8'h00, 7'd1,  5'd1};
    vecs[19] = '{1'b0, 8'h08, 1'b1, 13'd70,  8'h20, 7'd0,  5'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", vm_we, 0);
    chk("rst_waddr", vm_waddr, 0);
    chk("rst_wdata", vm_wdata, 0);
    chk("rst_roll", roll_cnt, 0);
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);
    chk("rst_vis", cursor_vis, 1);
    chk("rst_busy", busy, 0);
    clrn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", key_ready, 1);

    // Single-event table
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("v%0d_ready_pre", i), key_ready, 1);
      send_key(vecs[i].ext, vecs[i].code, nb);
      chk($sformatf("v%0d_busy_cycles", i), nb, 1);
      chk($sformatf("v%0d_nwrites", i), q_addr.size(), {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we && q_addr.size() > 0) begin
        chk($sformatf("v%0d_addr", i), q_addr[0], vecs[i].exp_addr);
        chk($sformatf("v%0d_data", i), q_data[0], vecs[i].exp_data);
      end
      chk($sformatf("v%0d_cx", i), cursor_x, vecs[i].exp_x);
      chk($sformatf("v%0d_cy", i), cursor_y, vecs[i].exp_y);
      chk($sformatf("v%0d_ready_post", i), key_ready, 1);
      chk($sformatf("v%0d_roll", i), roll_cnt, 0);
      $display("vec %0d ext=%0d code=%02h -> cursor (%0d,%0d) writes=%0d",
               i, vecs[i].ext, vecs[i].code, cursor_x, cursor_y, q_addr.size());
    end

    // Bottom-right printable: char write, wrap, scroll and bottom-row clear
    for (int i = 0; i < 28; i++) send_key(1'b1, 8'h72, nb);
    for (int i = 0; i < 69; i++) send_key(1'b1, 8'h74, nb);
    chk("corner_cx", cursor_x, 69);
    chk("corner_cy", cursor_y, 29);
    send_key(1'b0, 8'h5A, nb);
    chk("scroll_busy", nb, 71);
    chk("scroll_nwrites", q_addr.size(), 71);
    if (q_addr.size() == 71) begin
      chk("scroll_char_addr", q_addr[0], 2099);
      chk("scroll_char_data", q_data[0], 8'h5A);
      bad = 0;
      for (int i = 1; i < 71; i++)
        if (q_addr[i] != 13'(2100 + i - 1) || q_data[i] != 8'h20) bad++;
      chk("scroll_clear_row", bad, 0);
    end
    chk("scroll_roll", roll_cnt, 70);
    chk("scroll_cx", cursor_x, 0);
    chk("scroll_cy", cursor_y, 29);
    $display("scroll: roll=%0d cursor (%0d,%0d) busy=%0d", roll_cnt, cursor_x, cursor_y, nb);

    // Walk roll_cnt to the end of the ring, then wrap it with CR
    for (int i = 0; i < 115; i++) send_key(1'b0, 8'h0D, nb);
    chk("ring_roll_pre", roll_cnt, 8120);
    send_key(1'b0, 8'h0D, nb);
    chk("wrap_busy", nb, 71);
    chk("wrap_roll", roll_cnt, 0);
    chk("wrap_nwrites", q_addr.size(), 70);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] != 13'(2030 + i) || q_data[i] != 8'h20) bad++;
    chk("wrap_clear_row", bad, 0);
    $display("wrap: roll=%0d writes=%0d", roll_cnt, q_addr.size());

    // Clear request together with a key event
    q_addr.delete();
    q_data.delete();
    clear_req = 1'b1;
    key_valid = 1'b1;
    key_ext   = 1'b0;
    key_code  = 8'h51;
    #1;
    chk("clr_ready_held", key_ready, 0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    nb = 0;
    bad_ready = 0;
    while (busy && nb < 5000) begin
      nb++;
      if (key_ready) bad_ready++;
      if (vm_we) begin
        q_addr.push_back(vm_waddr);
        q_data.push_back(vm_wdata);
      end
      @(posedge clk); #1;
    end
    chk("clr_busy", nb, 2100);
    chk("clr_ready_low", bad_ready, 0);
    chk("clr_nwrites", q_addr.size(), 2100);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] != 13'(i) || q_data[i] != 8'h20) bad++;
    chk("clr_addrs", bad, 0);
    chk("clr_cx", cursor_x, 0);
    chk("clr_cy", cursor_y, 0);
    chk("clr_ready_after", key_ready, 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("clr_key_we", vm_we, 1);
    chk("clr_key_addr", vm_waddr, 0);
    chk("clr_key_data", vm_wdata, 8'h51);
    @(posedge clk); #1;
    chk("clr_key_cx", cursor_x, 1);
    $display("full clear: writes=%0d cursor (%0d,%0d)", q_addr.size(), cursor_x, cursor_y);

    // Reset dropped in the middle of a scroll clear
    for (int i = 0; i < 29; i++) send_key(1'b1, 8'h72, nb);
    key_valid = 1'b1;
    key_ext   = 1'b0;
    key_code  = 8'h0D;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_we", vm_we, 1);
    clrn = 1'b0;
    #1;
    chk("arst_we", vm_we, 0);
    chk("arst_waddr", vm_waddr, 0);
    chk("arst_wdata", vm_wdata, 0);
    chk("arst_roll", roll_cnt, 0);
    chk("arst_cx", cursor_x, 0);
    chk("arst_cy", cursor_y, 0);
    chk("arst_busy", busy, 0);
    chk("arst_vis", cursor_vis, 1);
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    chk("rel_busy", busy, 0);
    chk("rel_we", vm_we, 0);
    chk("rel_ready", key_ready, 1);
    send_key(1'b0, 8'h41, nb);
    chk("rel_key_busy", nb, 1);
    chk("rel_key_nwrites", q_addr.size(), 1);
    if (q_addr.size() == 1) chk("rel_key_addr", q_addr[0], 0);
    $display("reset mid-scroll: roll=%0d cursor (%0d,%0d)", roll_cnt, cursor_x, cursor_y);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
